// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3.
// One operand bit per cycle; result is published only when complete.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          r_state, w_state_n;
  logic [WIDTH-1:0] r_bin, w_bin_n;
  logic [AW-1:0]   r_acc, w_acc_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [AW-1:0]   r_bcd, w_bcd_n;
  logic            r_done, w_done_n;

  logic [AW-2:0]   w_adj;
  logic [AW-1:0]   w_acc_sh;
  logic [WIDTH-1:0] w_bin_sh;

  function automatic logic [3:0] adj3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Top digit's MSB is shifted out, so only its low 3 bits are kept.
  always_comb begin
    w_adj = '0;
    for (int k = 0; k < DIGITS - 1; k++) begin
      w_adj[4*k +: 4] = adj3(r_acc[4*k +: 4]);
    end
    w_adj[AW-2 -: 3] = (r_acc[AW-1 -: 4] >= 4'd5)
                     ? 3'(r_acc[AW-1 -: 4] + 4'd3)
                     : r_acc[AW-2 -: 3];
  end

  assign w_acc_sh = {w_adj, r_bin[WIDTH-1]};
  assign w_bin_sh = {r_bin[WIDTH-2:0], 1'b0};

  always_comb begin
    w_state_n = r_state;
    w_bin_n   = r_bin;
    w_acc_n   = r_acc;
    w_cnt_n   = r_cnt;
    w_bcd_n   = r_bcd;
    w_done_n  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_bin_n   = bin_in;
          w_acc_n   = '0;
          w_cnt_n   = CW'(WIDTH);
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        w_bin_n = w_bin_sh;
        w_acc_n = w_acc_sh;
        w_cnt_n = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_bcd_n   = w_acc_sh;
          w_done_n  = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_bin   <= w_bin_n;
      r_acc   <= w_acc_n;
      r_cnt   <= w_cnt_n;
      r_bcd   <= w_bcd_n;
      r_done  <= w_done_n;
    end
  end

  assign busy    = (r_state == SHIFT);
  assign done    = r_done;
  assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver queues expected results,
// a negedge monitor checks each done pulse for value and latency.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin_in = '0;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;

  logic [11:0] q_exp[$];
  int          q_cyc[$];

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bin_in(bin_in),
    .busy(busy),
    .done(done),
    .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest pending request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q_exp.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_done: got bcd %0h expected no pulse",
                 bcd_out);
      end else begin
        logic [11:0] e;
        int          c;
        e = q_exp.pop_front();
        c = q_cyc.pop_front();
        chk("bcd_value", bcd_out, e);
        chk("latency", cyc - c, 8);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      ncmp++;
      nerr++;
      $display("FAIL idle_timeout: busy stuck at 1 expected 0");
    end
  endtask

  task automatic send(input logic [7:0] v, input logic [11:0] e);
    @(negedge clk);
    wait_idle();
    bin_in = v;
    start  = 1'b1;
    q_exp.push_back(e);
    q_cyc.push_back(cyc + 1);
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;
  endtask

  task automatic drain();
    int n = 0;
    while (q_exp.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q_exp.size() != 0) begin
      ncmp++;
      nerr++;
      $display("FAIL drain_timeout: pending %0d expected 0",
               q_exp.size());
      q_exp.delete();
      q_cyc.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int prev;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 12'h000);
    rst_n = 1'b1;

    send(8'd0, 12'h000);
    chk("busy_during", busy, 1);
    drain();
    send(8'd255, 12'h255);
    drain();
    chk("done_one_cycle", done, 0);
    chk("bcd_hold", bcd_out, 12'h255);

    send(8'd99, 12'h099);
    send(8'd100, 12'h100);
    send(8'd200, 12'h200);
    send(8'd9, 12'h009);
    send(8'd10, 12'h010);
    drain();

    // Second start mid-conversion must be ignored.
    send(8'd37, 12'h037);
    @(negedge clk);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    start  = 1'b0;
    drain();
    chk("ignored_hold", bcd_out, 12'h037);

    // Abort with reset; start during reset must be dropped.
    send(8'd128, 12'h128);
    repeat (3) @(negedge clk);
    rst_n  = 1'b0;
    start  = 1'b1;
    bin_in = 8'd5;
    q_exp.delete();
    q_cyc.delete();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd_out, 12'h000);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_abort_bcd", bcd_out, 12'h000);
    send(8'd64, 12'h064);
    drain();

    // Continuous start: one result per 9 cycles.
    prev  = 0;
    start = 1'b1;
    for (int v = 0; v < 256; v++) begin
      wait_idle();
      bin_in = 8'(v);
      q_exp.push_back(to_bcd(v));
      q_cyc.push_back(cyc + 1);
      if (v > 0) chk("throughput", cyc + 1 - prev, 9);
      prev = cyc + 1;
      @(negedge clk);
      bin_in = ~8'(v);
    end
    start = 1'b0;
    drain();
    chk("final_bcd", bcd_out, 12'h255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded expected finish");
    $fatal(1);
  end

endmodule
